// File: rtl/keysw_device_if.sv
// ----------------------------------------------------------------------------
// keysw_device_if -- CPU memory-stage bus as seen by the KEY/SW device.
//
// Bus protocol: single-cycle strobes with no backpressure. The master holds
// abus/we/re/wdata for one clk cycle. The slave answers in the same cycle:
// sel and rdata are combinational from abus. Any state change caused by the
// access (store, read-clears-Ready) takes effect at the closing rising edge.
//
// Signals:
//   abus  [DBITS] master->slave  address
//   we           master->slave  store strobe
//   re           master->slave  load strobe
//   wdata [DBITS] master->slave  store data
//   rdata [DBITS] slave->master  load data, 0 when sel is 0
//   sel          slave->master  abus hits one of the device registers
// ----------------------------------------------------------------------------
interface keysw_device_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] abus;
  logic             we;
  logic             re;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             sel;

  modport master (
    output abus,
    output we,
    output re,
    output wdata,
    input  rdata,
    input  sel
  );

  modport slave (
    input  abus,
    input  we,
    input  re,
    input  wdata,
    output rdata,
    output sel
  );
endinterface

// File: rtl/keysw_device.sv
// ----------------------------------------------------------------------------
// keysw_device -- memory-mapped push-button (KEY) and slide-switch (SW) port.
//
// Each raw input vector is synchronized (two flops) and debounced: a new
// value is accepted only after the synchronized value has differed from the
// accepted value for DEBOUNCECYC consecutive clk cycles.
//
// Register map (word addresses, exact match only):
//   ADDRKEY     KDATA  R   debounced KEY (pressed = 1), zero-extended
//   ADDRKEY+4   KCTRL  RW  bit0 Ready, bit2 Overrun, bit8 IE
//   ADDRSW      SDATA  R   debounced SW, zero-extended
//   ADDRSW+4    SCTRL  RW  bit0 Ready, bit2 Overrun, bit8 IE
//
//   Ready   sets when the debounced value changes, clears when the data
//           register is read (re=1). A change wins over a same-cycle read.
//   Overrun sets when the debounced value changes while Ready is already 1;
//           only a control store with wdata[2]=0 clears it. Set wins.
//   IE      read/write through control stores (bit8).
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   KEY[3:0]  raw buttons, active-low, asynchronous
//   SW[9:0]   raw switches, asynchronous
//   bus       keysw_device_if.slave (abus/we/re/wdata in, rdata/sel out)
//   irq       registered interrupt request (only with KEYSW_IRQ_EN)
//
// Build option: define KEYSW_IRQ_EN to add the IE bits and the irq output.
// Without it there is no IE storage, bit8 reads 0 and stores to it are
// dropped.
// ----------------------------------------------------------------------------

// Synchronizer plus debounce counter for one input vector.
//   raw  asynchronous input (already in active-high form)
//   db   debounced value
//   chg  one-cycle pulse: db loads a new value at the coming edge
module keysw_debounce #(
  parameter int          W   = 4,
  parameter logic [31:0] CYC = 32'd500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db,
  output logic         chg
);
  logic [W-1:0] sync_1;
  logic [W-1:0] sync_2;
  logic [31:0]  cnt;
  logic         differ;

  assign differ = (sync_2 != db);
  // The counter holds how many differing cycles already went by, so the
  // CYC-th consecutive differing cycle is the one that sees CYC-1.
  assign chg    = differ && (cnt == CYC - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
      db     <= '0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (!differ) begin
        cnt <= '0;
      end else if (chg) begin
        // Load whatever is synchronized now; a value that wandered while
        // still differing is accepted as it stands at the end of the count.
        db  <= sync_2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end
endmodule

module keysw_device #(
  parameter int               DBITS       = 32,
  parameter logic [DBITS-1:0] ADDRKEY     = 32'hFFFFF080,
  parameter logic [DBITS-1:0] ADDRSW      = 32'hFFFFF090,
  parameter logic [31:0]      DEBOUNCECYC = 32'd500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          KEY,
  input  logic [9:0]          SW,
  keysw_device_if.slave       bus
`ifdef KEYSW_IRQ_EN
  ,
  output logic                irq
`endif
);
  localparam logic [DBITS-1:0] ADDR_KDATA = ADDRKEY;
  localparam logic [DBITS-1:0] ADDR_KCTRL = ADDRKEY + DBITS'(4);
  localparam logic [DBITS-1:0] ADDR_SDATA = ADDRSW;
  localparam logic [DBITS-1:0] ADDR_SCTRL = ADDRSW + DBITS'(4);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [3:0] k_db;
  logic [9:0] s_db;
  logic       k_chg;
  logic       s_chg;

  // KEY is inverted up front so that everything downstream sees pressed=1.
  keysw_debounce #(.W(4), .CYC(DEBOUNCECYC)) u_key_db (
    .clk   (clk),
    .reset (reset),
    .raw   (~KEY),
    .db    (k_db),
    .chg   (k_chg)
  );

  keysw_debounce #(.W(10), .CYC(DEBOUNCECYC)) u_sw_db (
    .clk   (clk),
    .reset (reset),
    .raw   (SW),
    .db    (s_db),
    .chg   (s_chg)
  );

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic k_rd;   // load from KDATA (clears KEY Ready)
  logic s_rd;   // load from SDATA (clears SW Ready)
  logic k_cw;   // store to KCTRL
  logic s_cw;   // store to SCTRL

  assign k_rd = bus.re && (bus.abus == ADDR_KDATA);
  assign s_rd = bus.re && (bus.abus == ADDR_SDATA);
  assign k_cw = bus.we && (bus.abus == ADDR_KCTRL);
  assign s_cw = bus.we && (bus.abus == ADDR_SCTRL);

  // Only wdata[2] and (optionally) wdata[8] matter; fold the rest away.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  // --------------------------------------------------------------------------
  // Ready / Overrun
  // --------------------------------------------------------------------------
  logic k_ready;
  logic k_ovr;
  logic s_ready;
  logic s_ovr;

  always_ff @(posedge clk) begin
    if (reset) begin
      k_ready <= 1'b0;
      k_ovr   <= 1'b0;
      s_ready <= 1'b0;
      s_ovr   <= 1'b0;
    end else begin
      // A fresh value outranks a same-cycle read so it is never lost.
      if (k_chg)     k_ready <= 1'b1;
      else if (k_rd) k_ready <= 1'b0;
      if (s_chg)     s_ready <= 1'b1;
      else if (s_rd) s_ready <= 1'b0;

      // The set event outranks a clearing store.
      if (k_chg && k_ready)              k_ovr <= 1'b1;
      else if (k_cw && !bus.wdata[2])    k_ovr <= 1'b0;
      if (s_chg && s_ready)              s_ovr <= 1'b1;
      else if (s_cw && !bus.wdata[2])    s_ovr <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt enable and request
  // --------------------------------------------------------------------------
  logic k_ie;
  logic s_ie;

`ifdef KEYSW_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      k_ie <= 1'b0;
      s_ie <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (k_cw) k_ie <= bus.wdata[8];
      if (s_cw) s_ie <= bus.wdata[8];
      // Registered from the current Ready/IE, hence one cycle behind them.
      irq <= (k_ready && k_ie) || (s_ready && s_ie);
    end
  end
`else
  assign k_ie = 1'b0;
  assign s_ie = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read mux (combinational, same cycle as the access)
  // --------------------------------------------------------------------------
  function automatic logic [DBITS-1:0] ctrl_word(input logic ie,
                                                 input logic ovr,
                                                 input logic rdy);
    logic [DBITS-1:0] w;
    w    = '0;
    w[8] = ie;
    w[2] = ovr;
    w[0] = rdy;
    return w;
  endfunction

  always_comb begin
    bus.rdata = '0;
    bus.sel   = 1'b0;
    if (bus.abus == ADDR_KDATA) begin
      bus.sel   = 1'b1;
      bus.rdata = DBITS'(k_db);
    end else if (bus.abus == ADDR_KCTRL) begin
      bus.sel   = 1'b1;
      bus.rdata = ctrl_word(k_ie, k_ovr, k_ready);
    end else if (bus.abus == ADDR_SDATA) begin
      bus.sel   = 1'b1;
      bus.rdata = DBITS'(s_db);
    end else if (bus.abus == ADDR_SCTRL) begin
      bus.sel   = 1'b1;
      bus.rdata = ctrl_word(s_ie, s_ovr, s_ready);
    end
  end
endmodule

// File: tb/tb_keysw_device.sv
// ----------------------------------------------------------------------------
// tb_keysw_device -- self-checking bench for keysw_device (DEBOUNCECYC=4).
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
// A behavioural model of the register rules runs on every rising edge.
// ----------------------------------------------------------------------------
module tb_keysw_device;
  localparam int          DBITS   = 32;
  localparam logic [31:0] ADDRKEY = 32'hFFFFF080;
  localparam logic [31:0] ADDRSW  = 32'hFFFFF090;
  localparam logic [31:0] KDATA   = ADDRKEY;
  localparam logic [31:0] KCTRL   = ADDRKEY + 32'd4;
  localparam logic [31:0] SDATA   = ADDRSW;
  localparam logic [31:0] SCTRL   = ADDRSW + 32'd4;
  localparam int          DEB     = 4;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] KEY   = 4'hF;
  logic [9:0] SW    = 10'h000;

  always #5 clk = ~clk;

  keysw_device_if #(.DBITS(DBITS)) bus ();
`ifdef KEYSW_IRQ_EN
  logic irq;
`endif

  keysw_device #(
    .DBITS       (DBITS),
    .ADDRKEY     (ADDRKEY),
    .ADDRSW      (ADDRSW),
    .DEBOUNCECYC (32'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .bus   (bus)
`ifdef KEYSW_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Index 0 = KEY device, 1 = SW device.
  bit [9:0] m_pipe0[$] = '{10'h0, 10'h0};
  bit [9:0] m_pipe1[$] = '{10'h0, 10'h0};
  bit [9:0] m_db[2]    = '{10'h0, 10'h0};
  int       m_run[2]   = '{0, 0};
  bit       m_ready[2] = '{1'b0, 1'b0};
  bit       m_ovr[2]   = '{1'b0, 1'b0};
  bit       m_ie[2]    = '{1'b0, 1'b0};
  int       m_acc[2]   = '{0, 0};
  bit       m_irq      = 1'b0;

  always @(posedge clk) begin
    bit [9:0]    cur[2];
    bit          chg;
    bit          rd;
    bit          cw;
    logic [31:0] base;
    if (reset) begin
      m_pipe0 = '{10'h0, 10'h0};
      m_pipe1 = '{10'h0, 10'h0};
      m_db    = '{10'h0, 10'h0};
      m_run   = '{0, 0};
      m_ready = '{1'b0, 1'b0};
      m_ovr   = '{1'b0, 1'b0};
      m_ie    = '{1'b0, 1'b0};
      m_irq   = 1'b0;
    end else begin
      m_irq = (m_ready[0] && m_ie[0]) || (m_ready[1] && m_ie[1]);
      // Two-stage delay line: the value seen now is the raw input of two
      // edges ago.
      m_pipe0.push_front({6'b0, ~KEY});
      cur[0] = m_pipe0.pop_back();
      m_pipe1.push_front(SW);
      cur[1] = m_pipe1.pop_back();
      for (int d = 0; d < 2; d++) begin
        base = (d == 0) ? ADDRKEY : ADDRSW;
        rd   = bus.re && (bus.abus == base);
        cw   = bus.we && (bus.abus == base + 32'd4);
        chg  = 1'b0;
        if (cur[d] != m_db[d]) begin
          m_run[d]++;
          if (m_run[d] == DEB) begin
            m_db[d]  = cur[d];
            m_run[d] = 0;
            chg      = 1'b1;
            m_acc[d]++;
          end
        end else begin
          m_run[d] = 0;
        end
        if (chg && m_ready[d])          m_ovr[d] = 1'b1;
        else if (cw && !bus.wdata[2])   m_ovr[d] = 1'b0;
        if (chg)     m_ready[d] = 1'b1;
        else if (rd) m_ready[d] = 1'b0;
`ifdef KEYSW_IRQ_EN
        if (cw) m_ie[d] = bus.wdata[8];
`endif
      end
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a == KDATA)      r = {22'b0, m_db[0]};
    else if (a == KCTRL) r = {23'b0, m_ie[0], 5'b0, m_ovr[0], 1'b0, m_ready[0]};
    else if (a == SDATA) r = {22'b0, m_db[1]};
    else if (a == SCTRL) r = {23'b0, m_ie[1], 5'b0, m_ovr[1], 1'b0, m_ready[1]};
    return r;
  endfunction

  function automatic logic exp_sel(input logic [31:0] a);
    return (a == KDATA) || (a == KCTRL) || (a == SDATA) || (a == SCTRL);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_cycle(input logic [31:0] a, input logic r,
                           input logic w, input logic [31:0] d);
    @(negedge clk);
    bus.abus  = a;
    bus.re    = r;
    bus.we    = w;
    bus.wdata = d;
    #1;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset     = 1'b1;
    bus.abus  = '0;
    bus.re    = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] regs[4]  = '{KDATA, KCTRL, SDATA, SCTRL};
    logic [31:0] holes[5] = '{32'h0, ADDRKEY + 32'd1, ADDRKEY + 32'd8,
                              ADDRSW + 32'd2, ADDRSW - 32'd4};
    apply_reset(2);
    foreach (regs[i]) begin
      bus_cycle(regs[i], 1'b1, 1'b0, 32'h0);
      n_chk++;
      if (bus.rdata !== 32'h0 || bus.sel !== 1'b1) begin
        n_err++;
        $display("FAIL reset_reg[%0d]: got rdata=%h sel=%b expected rdata=0 sel=1",
                 i, bus.rdata, bus.sel);
      end
    end
    foreach (holes[i]) begin
      bus_cycle(holes[i], 1'b1, 1'b1, 32'hFFFF_FFFF);
      n_chk++;
      if (bus.rdata !== 32'h0 || bus.sel !== 1'b0) begin
        n_err++;
        $display("FAIL unmapped[%h]: got rdata=%h sel=%b expected rdata=0 sel=0",
                 holes[i], bus.rdata, bus.sel);
      end
    end
`ifdef KEYSW_IRQ_EN
    n_chk++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
`endif
  endtask

  task automatic test_key_accept();
    logic [31:0] exp;
    KEY = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
      exp = (i >= 5) ? 32'h1 : 32'h0;
      n_chk++;
      if (bus.rdata !== exp) begin
        n_err++;
        $display("FAIL key_accept_kctrl[%0d]: got %h expected %h", i, bus.rdata, exp);
      end
    end
    bus_cycle(KDATA, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h1) begin
      n_err++;
      $display("FAIL key_accept_kdata: got %h expected 00000001", bus.rdata);
    end
    bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h0) begin
      n_err++;
      $display("FAIL key_ready_clear: got %h expected 00000000", bus.rdata);
    end
  endtask

  task automatic test_sw_bounce();
    for (int i = 0; i < 24; i++) begin
      SW = (i < 20 && ((i / 2) % 2) == 1) ? 10'h3FF : 10'h000;
      bus_cycle((i % 2) ? SCTRL : SDATA, 1'b1, 1'b0, 32'h0);
      n_chk++;
      if (bus.rdata !== 32'h0) begin
        n_err++;
        $display("FAIL sw_bounce[%0d]: got %h expected 00000000", i, bus.rdata);
      end
    end
  endtask

  task automatic test_overrun();
    SW = 10'h005;
    repeat (8) bus_cycle(32'h0, 1'b0, 1'b0, 32'h0);
    SW = 10'h00A;
    repeat (8) bus_cycle(32'h0, 1'b0, 1'b0, 32'h0);
    bus_cycle(SCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h5) begin
      n_err++;
      $display("FAIL overrun_set: got %h expected 00000005", bus.rdata);
    end
    bus_cycle(SCTRL, 1'b0, 1'b1, 32'h0);
    bus_cycle(SCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h1) begin
      n_err++;
      $display("FAIL overrun_clear: got %h expected 00000001", bus.rdata);
    end
    bus_cycle(SDATA, 1'b1, 1'b1, 32'hFFFF_FFFF);
    n_chk++;
    if (bus.rdata !== 32'h00A) begin
      n_err++;
      $display("FAIL sdata_value: got %h expected 0000000a", bus.rdata);
    end
    bus_cycle(SCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h0) begin
      n_err++;
      $display("FAIL sw_ready_clear: got %h expected 00000000", bus.rdata);
    end
  endtask

  task automatic test_read_at_accept();
    int  acc0;
    bit  found;
    acc0  = m_acc[0];
    found = 1'b0;
    KEY   = 4'b1100;
    // Keep reading KDATA every cycle; the read that coincides with the
    // accept edge must not clear the freshly set Ready.
    for (int i = 0; i < 12 && !found; i++) begin
      bus_cycle(KDATA, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      if (m_acc[0] != acc0) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_err++;
      $display("FAIL accept_timeout: got no accept expected one within 12 cycles");
    end
    bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h1) begin
      n_err++;
      $display("FAIL read_at_accept_kctrl: got %h expected 00000001", bus.rdata);
    end
    bus_cycle(KDATA, 1'b0, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h3) begin
      n_err++;
      $display("FAIL read_at_accept_kdata: got %h expected 00000003", bus.rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    KEY = 4'hF;
    apply_reset(2);
    @(negedge clk);
    KEY = 4'b0111;
    repeat (4) @(posedge clk);   // pending count reaches 2
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j == 0) begin
        bus_cycle(KDATA, 1'b1, 1'b0, 32'h0);
        n_chk++;
        if (bus.rdata !== 32'h0) begin
          n_err++;
          $display("FAIL reset_mid_kdata: got %h expected 00000000", bus.rdata);
        end
      end else begin
        bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
        exp = (j >= 5) ? 32'h1 : 32'h0;
        n_chk++;
        if (bus.rdata !== exp) begin
          n_err++;
          $display("FAIL reset_mid_kctrl[%0d]: got %h expected %h", j, bus.rdata, exp);
        end
      end
    end
    bus_cycle(KDATA, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h8) begin
      n_err++;
      $display("FAIL reset_mid_accept: got %h expected 00000008", bus.rdata);
    end
  endtask

  task automatic test_ie_irq();
    logic [31:0] exp_ctrl;
`ifdef KEYSW_IRQ_EN
    bit found;
    exp_ctrl = 32'h100;
`else
    exp_ctrl = 32'h0;
`endif
    bus_cycle(KCTRL, 1'b0, 1'b1, 32'h100);
    bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== exp_ctrl) begin
      n_err++;
      $display("FAIL ie_store: got %h expected %h", bus.rdata, exp_ctrl);
    end
`ifdef KEYSW_IRQ_EN
    found = 1'b0;
    KEY   = 4'b1101;
    for (int i = 0; i < 12 && !found; i++) begin
      bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
      if (m_ready[0]) begin
        found = 1'b1;
        n_chk++;
        if (bus.rdata !== 32'h101 || irq !== 1'b0) begin
          n_err++;
          $display("FAIL irq_ready_cycle: got ctrl=%h irq=%b expected ctrl=00000101 irq=0",
                   bus.rdata, irq);
        end
      end
    end
    n_chk++;
    if (!found) begin
      n_err++;
      $display("FAIL irq_accept_timeout: got no Ready expected one within 12 cycles");
    end
    bus_cycle(KDATA, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h2 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_assert: got kdata=%h irq=%b expected kdata=00000002 irq=1",
               bus.rdata, irq);
    end
    bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h100 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_lag: got ctrl=%h irq=%b expected ctrl=00000100 irq=1",
               bus.rdata, irq);
    end
    bus_cycle(KCTRL, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_deassert: got %b expected 0", irq);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) KEY = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) SW  = 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 6))
        0:       a = KDATA;
        1:       a = KCTRL;
        2:       a = SDATA;
        3:       a = SCTRL;
        4:       a = ADDRKEY + 32'd1;
        5:       a = ADDRSW + 32'd8;
        default: a = $urandom;
      endcase
      bus_cycle(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
      exp = exp_rdata(a);
      n_chk++;
      if (bus.rdata !== exp || bus.sel !== exp_sel(a)) begin
        n_err++;
        $display("FAIL random[%0d] addr=%h: got rdata=%h sel=%b expected rdata=%h sel=%b",
                 i, a, bus.rdata, bus.sel, exp, exp_sel(a));
      end
`ifdef KEYSW_IRQ_EN
      n_chk++;
      if (irq !== m_irq) begin
        n_err++;
        $display("FAIL random_irq[%0d]: got %b expected %b", i, irq, m_irq);
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.abus  = '0;
    bus.re    = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_key_accept();
    test_sw_bounce();
    test_overrun();
    test_read_at_accept();
    test_reset_mid();
    test_ie_irq();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test sequence to finish");
    $fatal(1, "watchdog expired");
  end
endmodule
